// File: rtl/axis_byte_packer_if.sv
// AXI4-Stream handshake bundle (TDATA/TVALID/TREADY only), width set per instance.
interface axis_byte_packer_if #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI4-Stream into little-endian PACK_BYTES-wide words on a
// registered AXI4-Stream master, counting words taken downstream.
//
// state | meaning
// EMPTY | output register holds no word, m_axis.tvalid=0
// FULL  | output register holds a word awaiting m_axis.tready
module axis_byte_packer #(
  parameter int PACK_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  axis_byte_packer_if.slave   s_axis,
  axis_byte_packer_if.master  m_axis,
  output logic [CNT_W-1:0]    word_cnt
);

  localparam int IW = $clog2(PACK_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(PACK_BYTES - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                        state, state_nxt;
  logic [IW-1:0]                 idx;
  logic [8*(PACK_BYTES-1)-1:0]   acc;
  logic [8*PACK_BYTES-1:0]       out_word;
  logic                          last, s_ready, s_fire, final_fire, m_fire, load;

  assign last       = (idx == LAST_IDX);
  // Only path from m_axis.tready to s_axis.tready: the final byte may enter
  // in the same cycle the held word drains.
  assign s_ready    = aresetn & (~last | (state == EMPTY) | m_axis.tready);
  assign s_fire     = s_axis.tvalid & s_ready;
  assign final_fire = s_fire & last;
  assign m_fire     = (state == FULL) & m_axis.tready;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state == FULL);
  assign m_axis.tdata  = out_word;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      EMPTY: begin
        if (final_fire) begin
          state_nxt = FULL;
          load      = 1'b1;
        end
      end
      FULL: begin
        if (final_fire) begin
          load = 1'b1;
        end else if (m_axis.tready) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state    <= EMPTY;
      idx      <= '0;
      acc      <= '0;
      out_word <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (s_fire) begin
        if (last) begin
          idx <= '0;
        end else begin
          idx <= idx + IW'(1);
          for (int k = 0; k < PACK_BYTES - 1; k++) begin
            if (idx == IW'(k)) acc[8*k +: 8] <= s_axis.tdata;
          end
        end
      end
      if (load) out_word <= {s_axis.tdata, acc};
      if (m_fire) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed scoreboard bench for axis_byte_packer (PACK_BYTES=4, CNT_W=4 so the
// long random-gap run wraps the word counter).
module tb_axis_byte_packer;

  localparam int PB = 4;
  localparam int CW = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] word_cnt;

  axis_byte_packer_if #(.W(8))    s_if ();
  axis_byte_packer_if #(.W(8*PB)) m_if ();

  axis_byte_packer #(.PACK_BYTES(PB), .CNT_W(CW)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .word_cnt (word_cnt)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  logic rdy_cmd = 1'b1;
  logic rnd_en  = 1'b0;
  logic rnd_rdy = 1'b1;
  assign m_if.tready = rnd_en ? rnd_rdy : rdy_cmd;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Random downstream ready: one ready cycle followed by 0-3 stalled cycles.
  initial begin
    int gap = 0;
    forever begin
      @(posedge aclk); #1;
      if (gap > 0) begin
        rnd_rdy = 1'b0;
        gap--;
      end else begin
        rnd_rdy = 1'b1;
        gap = $urandom_range(0, 3);
      end
    end
  end

  // Monitor: pop/compare on every output handshake, and check hold stability.
  initial begin
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    forever begin
      @(negedge aclk);
      if (aresetn && prev_stall) begin
        check("hold_tvalid", m_if.tvalid, 1'b1);
        check("hold_tdata", m_if.tdata, prev_data);
      end
      if (aresetn && m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", m_if.tdata, 64'hDEAD_0000_0000);
        end else begin
          check("word", m_if.tdata, exp_q.pop_front());
        end
      end
      prev_stall = aresetn & m_if.tvalid & ~m_if.tready;
      prev_data  = m_if.tdata;
    end
  end

  task automatic send_byte(input logic [7:0] b, output int stalls);
    logic acc;
    stalls = 0;
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      acc = s_if.tready;
      @(posedge aclk); #1;
      if (acc) break;
      stalls++;
      if (stalls > 200) begin
        check("send_timeout", stalls, 0);
        break;
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output int stalls);
    int st;
    stalls = 0;
    for (int i = 0; i < PB; i++) begin
      send_byte(w[8*i +: 8], st);
      stalls += st;
    end
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", s_if.tready, 1'b0);
    check("rst_m_tvalid", m_if.tvalid, 1'b0);
    check("rst_m_tdata", m_if.tdata, 32'h0);
    check("rst_word_cnt", word_cnt, 4'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [31:0] w;
    logic [7:0]  b;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;

    // 1: single word, latency and count
    do_reset();
    rdy_cmd = 1'b1;
    exp_q.push_back(32'h4433_2211);
    send_word(32'h4433_2211, st);
    @(negedge aclk);
    check("t1_tvalid", m_if.tvalid, 1'b1);
    check("t1_tdata", m_if.tdata, 32'h4433_2211);
    @(negedge aclk);
    check("t1_word_cnt", word_cnt, 4'd1);
    wait_drain();

    // 2: 16 streaming bytes, no bubbles
    do_reset();
    exp_q.push_back(32'h0302_0100);
    exp_q.push_back(32'h0706_0504);
    exp_q.push_back(32'h0B0A_0908);
    exp_q.push_back(32'h0F0E_0D0C);
    send_word(32'h0302_0100, st); w = st;
    send_word(32'h0706_0504, st); w += st;
    send_word(32'h0B0A_0908, st); w += st;
    send_word(32'h0F0E_0D0C, st); w += st;
    check("t2_stalls", w, 0);
    wait_drain();
    check("t2_word_cnt", word_cnt, 4'd4);

    // 3: backpressure stalls only the final byte
    do_reset();
    rdy_cmd = 1'b0;
    exp_q.push_back(32'h0302_0100);
    exp_q.push_back(32'h0706_0504);
    send_word(32'h0302_0100, st);
    w = 0;
    for (int i = 4; i < 7; i++) begin
      send_byte(8'(i), st);
      w += st;
    end
    check("t3_nonfinal_stalls", w, 0);
    s_if.tdata  = 8'h07;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      check("t3_s_tready_low", s_if.tready, 1'b0);
      check("t3_held_tdata", m_if.tdata, 32'h0302_0100);
    end
    @(posedge aclk); #1;
    rdy_cmd = 1'b1;
    @(negedge aclk);
    check("t3_s_tready_release", s_if.tready, 1'b1);
    @(posedge aclk); #1;
    s_if.tvalid = 1'b0;
    @(negedge aclk);
    check("t3_new_tdata", m_if.tdata, 32'h0706_0504);
    wait_drain();

    // 4: drain and final-byte load in the same cycle
    do_reset();
    rdy_cmd = 1'b0;
    exp_q.push_back(32'h1312_1110);
    exp_q.push_back(32'h1716_1514);
    send_word(32'h1312_1110, st);
    for (int i = 0; i < 3; i++) send_byte(8'(8'h14 + i), st);
    rdy_cmd = 1'b1;
    send_byte(8'h17, st);
    check("t4_final_stalls", st, 0);
    @(negedge aclk);
    check("t4_tvalid", m_if.tvalid, 1'b1);
    check("t4_tdata", m_if.tdata, 32'h1716_1514);
    wait_drain();
    check("t4_word_cnt", word_cnt, 4'd2);

    // 5: reset discards a partial word
    do_reset();
    send_byte(8'hAA, st);
    send_byte(8'hBB, st);
    aresetn = 1'b0;
    @(negedge aclk);
    check("t5_s_tready_in_rst", s_if.tready, 1'b0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    exp_q.push_back(32'h0403_0201);
    send_word(32'h0403_0201, st);
    wait_drain();
    check("t5_word_cnt", word_cnt, 4'd1);

    // 6: random gaps both sides, 68 bytes, counter wraps at 16
    do_reset();
    rnd_en = 1'b1;
    w = '0;
    for (int i = 0; i < 68; i++) begin
      b = 8'(i * 37 + 5);
      w[8*(i % PB) +: 8] = b;
      if (i % PB == PB - 1) exp_q.push_back(w);
      repeat ($urandom_range(0, 3)) @(posedge aclk);
      #1;
      send_byte(b, st);
    end
    rdy_cmd = 1'b1;
    rnd_en  = 1'b0;
    wait_drain();
    check("t6_word_cnt", word_cnt, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
